// File: rtl/mux_nx1_scan.sv
// N-channel registered mux with manual select and auto-scan modes.
// Scan mode visits each channel for DWELL cycles and pulses y_valid on the last one.
module mux_nx1_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int DWELL    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         mode,
  input  logic [$clog2(CHANNELS)-1:0]  sel_in,
  input  logic [CHANNELS*WIDTH-1:0]    d_in,
  output logic [WIDTH-1:0]             y_out,
  output logic [$clog2(CHANNELS)-1:0]  ch_out,
  output logic                         y_valid
);

  localparam int SEL_W = $clog2(CHANNELS);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCAN
  } state_t;

  state_t             state;
  state_t             nxt;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   ptr_n;
  logic [SEL_W-1:0]   eff_ptr;
  logic [SEL_W-1:0]   pick;
  logic [SEL_W-1:0]   ch_n;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_n;
  logic [CNT_W-1:0]   eff_cnt;
  logic [WIDTH-1:0]   chan_sel;
  logic [WIDTH-1:0]   y_n;
  logic               v_n;
  logic               sel_ok;
  logic               last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = IDLE;
    unique case (1'b1)
      !en:          nxt = IDLE;
      en && !mode:  nxt = MANUAL;
      en && mode:   nxt = SCAN;
      default:      nxt = IDLE;
    endcase
  end

  // A fresh scan always starts from channel 0, whatever ptr/cnt hold.
  assign eff_ptr = (state == SCAN) ? ptr : '0;
  assign eff_cnt = (state == SCAN) ? cnt : '0;
  assign last    = (eff_cnt == CNT_W'(DWELL - 1));
  assign sel_ok  = ({1'b0, sel_in} < (SEL_W + 1)'(CHANNELS));
  assign pick    = (nxt == SCAN) ? eff_ptr : sel_in;

  always_comb begin
    chan_sel = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (pick == SEL_W'(k)) chan_sel = d_in[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    y_n   = y_out;
    ch_n  = ch_out;
    v_n   = 1'b0;
    ptr_n = '0;
    cnt_n = '0;
    unique case (nxt)
      MANUAL: begin
        if (sel_ok) begin
          y_n  = chan_sel;
          ch_n = sel_in;
          v_n  = 1'b1;
        end
      end
      SCAN: begin
        y_n  = chan_sel;
        ch_n = eff_ptr;
        if (last) begin
          v_n   = 1'b1;
          cnt_n = '0;
          ptr_n = (eff_ptr == SEL_W'(CHANNELS - 1))
                ? '0 : eff_ptr + SEL_W'(1);
        end else begin
          cnt_n = eff_cnt + CNT_W'(1);
          ptr_n = eff_ptr;
        end
      end
      IDLE:    ;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_out   <= '0;
      ch_out  <= '0;
      y_valid <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      y_out   <= y_n;
      ch_out  <= ch_n;
      y_valid <= v_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
    end
  end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Bench for mux_nx1_scan: 8ch/dwell 4 and 5ch/dwell 1 instances
// driven in lockstep and checked against a scan-count reference model.
module tb_mux_nx1_scan;

  logic        clk = 1'b0;
  logic        rst, en, mode;
  logic [2:0]  sel;
  logic [63:0] d;
  logic [7:0]  ya, yb;
  logic [2:0]  cha, chb;
  logic        va, vb;

  int errs   = 0;
  int checks = 0;

  int       CH [2] = '{8, 5};
  int       DW [2] = '{4, 1};
  logic [7:0] my [2];
  int       mc [2];
  logic     mv [2];
  int       n  [2];

  always #5 clk = ~clk;

  mux_nx1_scan #(.WIDTH(8), .CHANNELS(8), .DWELL(4)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel),
    .d_in(d), .y_out(ya), .ch_out(cha), .y_valid(va)
  );

  mux_nx1_scan #(.WIDTH(8), .CHANNELS(5), .DWELL(1)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel),
    .d_in(d[39:0]), .y_out(yb), .ch_out(chb), .y_valid(vb)
  );

  // Scan position is derived from the count of consecutive scan edges.
  task automatic model_step();
    int p;
    for (int id = 0; id < 2; id++) begin
      if (rst) begin
        my[id] = '0; mc[id] = 0; mv[id] = 1'b0; n[id] = 0;
      end else if (!en) begin
        mv[id] = 1'b0; n[id] = 0;
      end else if (!mode) begin
        n[id] = 0;
        if (int'(sel) < CH[id]) begin
          my[id] = d[int'(sel)*8 +: 8];
          mc[id] = int'(sel);
          mv[id] = 1'b1;
        end else begin
          mv[id] = 1'b0;
        end
      end else begin
        p = (n[id] / DW[id]) % CH[id];
        my[id] = d[p*8 +: 8];
        mc[id] = p;
        mv[id] = ((n[id] % DW[id]) == DW[id] - 1);
        n[id]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'($urandom);
    sel = 3'($urandom); d = {$urandom, $urandom};
    tick(); tick();
    checks++;
    if ({ya, cha, va} !== 12'h0) begin
      errs++;
      $display("FAIL reset_a y=%h ch=%0d v=%b want 0", ya, cha, va);
    end
    checks++;
    if ({yb, chb, vb} !== 12'h0) begin
      errs++;
      $display("FAIL reset_b y=%h ch=%0d v=%b want 0", yb, chb, vb);
    end
    rst = 1'b0;
  endtask

  task automatic test_manual_sweep();
    logic [7:0] exp;
    en = 1'b1; mode = 1'b0;
    for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'h01 << k;
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k);
      tick();
      exp = 8'h01 << k;
      checks++;
      if (ya !== exp || cha !== 3'(k) || va !== 1'b1) begin
        errs++;
        $display("FAIL manual_a k=%0d y=%h ch=%0d v=%b want %h %0d 1",
                 k, ya, cha, va, exp, k);
      end
      checks++;
      if (yb !== my[1] || chb !== 3'(mc[1]) || vb !== mv[1]) begin
        errs++;
        $display("FAIL manual_b k=%0d y=%h ch=%0d v=%b want %h %0d %b",
                 k, yb, chb, vb, my[1], mc[1], mv[1]);
      end
    end
  endtask

  task automatic test_scan_wrap();
    int pulses = 0;
    for (int k = 0; k < 8; k++) d[k*8 +: 8] = 8'hA0 + 8'(k);
    mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (ya !== my[0] || cha !== 3'(mc[0]) || va !== mv[0]) begin
        errs++;
        $display("FAIL scan_a i=%0d y=%h ch=%0d v=%b want %h %0d %b",
                 i, ya, cha, va, my[0], mc[0], mv[0]);
      end
      checks++;
      if (yb !== my[1] || chb !== 3'(mc[1]) || vb !== mv[1]) begin
        errs++;
        $display("FAIL scan_b i=%0d y=%h ch=%0d v=%b want %h %0d %b",
                 i, yb, chb, vb, my[1], mc[1], mv[1]);
      end
      if (va) pulses++;
    end
    checks++;
    if (pulses !== 10) begin
      errs++;
      $display("FAIL scan_pulses got=%0d want 10", pulses);
    end
  endtask

  task automatic test_mode_switch();
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; mode = 1'b1;
    repeat (14) tick();
    mode = 1'b0; sel = 3'd5;
    tick();
    checks++;
    if (cha !== 3'd5 || va !== 1'b1 || ya !== 8'hA5) begin
      errs++;
      $display("FAIL switch_manual y=%h ch=%0d v=%b want a5 5 1",
               ya, cha, va);
    end
    mode = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (cha !== 3'd0 || va !== (i == 4)) begin
        errs++;
        $display("FAIL switch_rescan i=%0d ch=%0d v=%b want 0 %b",
                 i, cha, va, i == 4);
      end
      checks++;
      if (yb !== my[1] || chb !== 3'(mc[1]) || vb !== mv[1]) begin
        errs++;
        $display("FAIL switch_b i=%0d y=%h ch=%0d v=%b want %h %0d %b",
                 i, yb, chb, vb, my[1], mc[1], mv[1]);
      end
    end
  endtask

  task automatic test_disable_reset();
    logic [7:0] held;
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; mode = 1'b1;
    repeat (10) tick();
    held = ya;
    en = 1'b0;
    repeat (2) begin
      tick();
      checks++;
      if (va !== 1'b0 || ya !== held) begin
        errs++;
        $display("FAIL disable y=%h v=%b want %h 0", ya, va, held);
      end
    end
    en = 1'b1;
    repeat (24) tick();
    checks++;
    if (cha !== 3'd5 || va !== 1'b1) begin
      errs++;
      $display("FAIL pre_rst ch=%0d v=%b want 5 1", cha, va);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({ya, cha, va} !== 12'h0) begin
      errs++;
      $display("FAIL mid_rst y=%h ch=%0d v=%b want 0", ya, cha, va);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (cha !== 3'd0 || ya !== 8'hA0 || va !== 1'b0) begin
      errs++;
      $display("FAIL post_rst y=%h ch=%0d v=%b want a0 0 0", ya, cha, va);
    end
  endtask

  task automatic test_small_channels();
    en = 1'b1; mode = 1'b0; sel = 3'd2;
    tick();
    sel = 3'd6;
    tick();
    checks++;
    if (vb !== 1'b0 || chb !== 3'd2 || yb !== 8'hA2) begin
      errs++;
      $display("FAIL small_oob y=%h ch=%0d v=%b want a2 2 0", yb, chb, vb);
    end
    mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (chb !== 3'(i % 5) || vb !== 1'b1 || yb !== 8'hA0 + 8'(i % 5)) begin
        errs++;
        $display("FAIL small_scan i=%0d y=%h ch=%0d v=%b want ch %0d v 1",
                 i, yb, chb, vb, i % 5);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) en = 1'($urandom);
      if ($urandom_range(0, 14) == 0) mode = 1'($urandom);
      sel = 3'($urandom);
      if ($urandom_range(0, 3) == 0) d = {$urandom, $urandom};
      tick();
      checks++;
      if (ya !== my[0] || cha !== 3'(mc[0]) || va !== mv[0]) begin
        errs++;
        $display("FAIL rand_a i=%0d y=%h ch=%0d v=%b want %h %0d %b",
                 i, ya, cha, va, my[0], mc[0], mv[0]);
      end
      checks++;
      if (yb !== my[1] || chb !== 3'(mc[1]) || vb !== mv[1]) begin
        errs++;
        $display("FAIL rand_b i=%0d y=%h ch=%0d v=%b want %h %0d %b",
                 i, yb, chb, vb, my[1], mc[1], mv[1]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0; d = '0;
    for (int id = 0; id < 2; id++) begin
      my[id] = '0; mc[id] = 0; mv[id] = 1'b0; n[id] = 0;
    end
    test_reset();
    test_manual_sweep();
    test_scan_wrap();
    test_mode_switch();
    test_disable_reset();
    test_small_channels();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
